// File: rtl/uncrop_pad.sv
// Places a cropped raster image back into a larger frame, emitting PAD_VALUE outside the window.
// Optional macro UNCROP_FRAME_TAGS_EN adds registered start-of-frame / end-of-line tags.
module uncrop_pad #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20,
  parameter int OUT_ROWS        = 40,
  parameter int OUT_COLS        = 40,
  parameter int Y_1             = 10,
  parameter int X_1             = 10,
  parameter int PAD_VALUE       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef UNCROP_FRAME_TAGS_EN
  ,
  output logic                       out_sof,
  output logic                       out_eol
`endif
);

  localparam int XW = $clog2(OUT_COLS) + 1;
  localparam int YW = $clog2(OUT_ROWS) + 1;
  localparam logic [XW-1:0] X_LO   = XW'(X_1);
  localparam logic [XW-1:0] X_SPAN = XW'(IN_COLS);
  localparam logic [XW-1:0] X_MAX  = XW'(OUT_COLS - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(Y_1);
  localparam logic [YW-1:0] Y_SPAN = YW'(IN_ROWS);
  localparam logic [YW-1:0] Y_MAX  = YW'(OUT_ROWS - 1);
  localparam logic [PIXEL_BIT_WIDTH-1:0] PAD = PIXEL_BIT_WIDTH'(PAD_VALUE);

  generate
    if ((Y_1 + IN_ROWS > OUT_ROWS) || (X_1 + IN_COLS > OUT_COLS)) begin : g_bad_window
      $error("uncrop_pad: crop window does not fit inside the output frame");
    end
  endgenerate

  logic [XW-1:0]              r_x;
  logic [YW-1:0]              r_y;
  logic [PIXEL_BIT_WIDTH-1:0] r_pix;
  logic                       r_vld;
  logic [XW-1:0]              w_dx;
  logic [YW-1:0]              w_dy;
  logic                       w_inside;
  logic                       w_room;
  logic                       w_load;

  // Counters carry one spare bit, so a coordinate left of the window wraps to a
  // difference >= the frame size and a single unsigned compare covers both edges.
  assign w_dx     = r_x - X_LO;
  assign w_dy     = r_y - Y_LO;
  assign w_inside = (w_dx < X_SPAN) && (w_dy < Y_SPAN);
  assign w_room   = !r_vld || out_ready;
  assign w_load   = w_room && (!w_inside || in_valid);
  assign in_ready = reset && w_inside && w_room;

  assign pixel_out = r_pix;
  assign out_valid = r_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_pix <= '0;
      r_vld <= 1'b0;
    end else if (w_load) begin
      r_pix <= w_inside ? pixel_in : PAD;
      r_vld <= 1'b1;
      if (r_x == X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == Y_MAX) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

`ifdef UNCROP_FRAME_TAGS_EN
  logic r_sof;
  logic r_eol;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sof <= 1'b0;
      r_eol <= 1'b0;
    end else if (w_load) begin
      r_sof <= (r_x == '0) && (r_y == '0);
      r_eol <= (r_x == X_MAX);
    end
  end

  assign out_sof = r_sof;
  assign out_eol = r_eol;
`endif

endmodule

// File: doc/uncrop_pad.md
UNCROP_PAD -- requirements
Module: uncrop_pad

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 12, pixel width in bits.
REQ-002 SHALL have parameter IN_ROWS, default 20, rows of the cropped input image.
REQ-003 SHALL have parameter IN_COLS, default 20, columns of the cropped input image.
REQ-004 SHALL have parameter OUT_ROWS, default 40, rows of the reconstructed output frame.
REQ-005 SHALL have parameter OUT_COLS, default 40, columns of the reconstructed output frame.
REQ-006 SHALL have parameter Y_1, default 10, output row of the window's top edge.
REQ-007 SHALL have parameter X_1, default 10, output column of the window's left edge.
REQ-008 SHALL have parameter PAD_VALUE, default 0, pixel value emitted outside the window.
REQ-009 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-010 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pixel_in, input, PIXEL_BIT_WIDTH, cropped pixel, raster order.
REQ-012 SHALL have port in_valid, input, 1, pixel_in valid.
REQ-013 SHALL have port in_ready, output, 1, block accepts pixel_in this cycle.
REQ-014 SHALL have port pixel_out, output, PIXEL_BIT_WIDTH, reconstructed pixel, raster order.
REQ-015 SHALL have port out_valid, output, 1, pixel_out valid.
REQ-016 SHALL have port out_ready, input, 1, downstream accepts pixel_out.

Function
REQ-017 SHALL track output coordinates x (0..OUT_COLS-1) and y (0..OUT_ROWS-1) of the next pixel to load.
REQ-018 SHALL define inside = (Y_1 <= y < Y_1+IN_ROWS) and (X_1 <= x < X_1+IN_COLS).
REQ-019 SHALL define load = (!out_valid or out_ready) and (!inside or in_valid).
REQ-020 SHALL drive in_ready = inside and (!out_valid or out_ready), combinationally.
REQ-021 SHALL on load register pixel_out = pixel_in if inside, else PAD_VALUE, and set out_valid = 1.
REQ-022 SHALL clear out_valid when out_valid and out_ready and not load.
REQ-023 SHALL hold pixel_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL on load advance x; at x=OUT_COLS-1 wrap x to 0 and advance y; at y=OUT_ROWS-1 also wrap y to 0.
REQ-025 SHALL give latency of exactly one cycle from handshake (or pad load) to out_valid.
REQ-026 SHALL sustain one output pixel per cycle under continuous in_valid and out_ready.
REQ-027 SHALL never consume input outside the window; pad pixels are emitted regardless of in_valid.
REQ-028 SHALL stall with out_valid=0 inside the window when in_valid=0 and the register is empty or draining.
REQ-029 SHALL ignore pixel_in when in_ready=0.
REQ-030 SHALL treat Y_1+IN_ROWS > OUT_ROWS or X_1+IN_COLS > OUT_COLS as an elaboration error.
REQ-031 SHALL size counters as $clog2(OUT_COLS)+1 and $clog2(OUT_ROWS)+1 bits.

Reset
REQ-032 SHALL on reset low asynchronously set x=0, y=0, out_valid=0, pixel_out=0.
REQ-033 SHALL on reset mid-frame discard the partial frame and restart at output (0,0) after release.
REQ-034 SHALL hold in_ready=0 while reset is low.

Configuration
REQ-035 SHALL with macro UNCROP_FRAME_TAGS_EN defined add outputs out_sof and out_eol (1 bit each), registered with pixel_out.
REQ-036 SHALL set out_sof=1 only for output (0,0) and out_eol=1 only for x=OUT_COLS-1; both reset to 0.
REQ-037 SHALL without UNCROP_FRAME_TAGS_EN omit both ports; all other behaviour identical.

Verification (OUT 4x4, IN 2x2, Y_1=1, X_1=1, PAD_VALUE=0 unless noted)
REQ-038 SHALL check: input 1,2,3,4 with in_valid and out_ready held high -> 16 outputs 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0.
REQ-039 SHALL check: in_valid=0 throughout -> first 5 pad pixels emitted, then out_valid=0 stall at (1,1), in_ready=1.
REQ-040 SHALL check: out_ready=0 for 3 cycles while pixel_out=2 -> pixel_out=2, out_valid=1 held, in_ready=0.
REQ-041 SHALL check: two frames back-to-back, inputs 1..8 -> second frame starts with pad at (0,0) with no bubble, shows 5,6,7,8.
REQ-042 SHALL check: reset low after 7 outputs -> out_valid=0 at once; after release the next output is frame position (0,0).
REQ-043 SHALL check with UNCROP_FRAME_TAGS_EN: out_sof=1 on output 0 and 16, out_eol=1 on outputs 3,7,11,15.
